dpram_rr_arbiter: RTL

//  Shares one true dual-port RAM (2 ports, write-first, registered dout, collision flag) among
//  NUM_REQ requesters. Each cycle, round-robin arbitration grants up to two requests: first to

---
 rtl/dpram_rr_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter
//   Shares one true dual-port, write-first RAM with a registered read port
//   among NUM_REQ requesters. Each cycle a round-robin scan starting at the
//   rotating pointer grants up to two requests: the first valid one goes to
//   port A, the next one that does not hit A's address (when either of them
//   writes) goes to port B. A request that conflicts is deferred to a later
//   cycle. Read data returns on the cycle after the grant, steered to the
//   requester that issued the read.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   DATA_WIDTH RAM word width
//   ADDR_WIDTH RAM address width
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/we        per-requester request and write flag
//   req_addr/wdata      packed per-requester address and write data
//   req_ready           grant; a request transfers when valid & ready
//   rsp_valid/rdata     per-requester read response pulse and held data
//   ram_*_a / ram_*_b   RAM port A/B controls and registered read data
//   ram_collision       RAM flag for two writes to one address
//   err_collision       sticky record of ram_collision
//
// Optional feature
//   ARB_STATS_EN adds conflict_cnt[15:0], a saturating count of cycles in
//   which a valid request was deferred because of an address conflict.

module dpram_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  output logic                           ram_we_a,
  output logic [ADDR_WIDTH-1:0]          ram_addr_a,
  output logic [DATA_WIDTH-1:0]          ram_din_a,
  input  logic [DATA_WIDTH-1:0]          ram_dout_a,
  output logic                           ram_we_b,
  output logic [ADDR_WIDTH-1:0]          ram_addr_b,
  output logic [DATA_WIDTH-1:0]          ram_din_b,
  input  logic [DATA_WIDTH-1:0]          ram_dout_b,
  input  logic                           ram_collision,
  output logic                           err_collision
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                    conflict_cnt
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] reqAddr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] reqWdata [NUM_REQ];
  logic [DATA_WIDTH-1:0] rspData  [NUM_REQ];
  logic [DATA_WIDTH-1:0] rdataHold_q [NUM_REQ];

  logic [IDW-1:0] rrPtr_q, rrPtr_d;
  logic           grantA, grantB;
  logic [IDW-1:0] idA, idB, lastId;
  logic           tagValidA_q, tagValidA_d, tagValidB_q, tagValidB_d;
  logic [IDW-1:0] tagIdA_q, tagIdB_q;
  logic           errCollision_q;
`ifdef ARB_STATS_EN
  logic           conflictSeen;
  logic [15:0]    conflictCnt_q;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : gPack
    assign reqAddr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign reqWdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rspData[g];
  end

  // Round-robin scan starting at rrPtr_q. Grants are suppressed while reset
  // is asserted so nothing reaches the RAM during reset. Once port A is
  // taken, a candidate for B that shares A's address while either side
  // writes is skipped rather than ending the scan.
  always_comb begin
    logic [IDW:0] scanIdx;
    logic [IDW-1:0] idx;
    grantA  = 1'b0;
    grantB  = 1'b0;
    idA     = '0;
    idB     = '0;
    scanIdx = '0;
    idx     = '0;
`ifdef ARB_STATS_EN
    conflictSeen = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = {1'b0, rrPtr_q} + (IDW+1)'(k);
      if (scanIdx >= (IDW+1)'(NUM_REQ)) begin
        scanIdx = scanIdx - (IDW+1)'(NUM_REQ);
      end
      idx = scanIdx[IDW-1:0];
      if (rst_n && req_valid[idx]) begin
        if (!grantA) begin
          grantA = 1'b1;
          idA    = idx;
        end else if (!grantB) begin
          if ((reqAddr[idx] == reqAddr[idA]) && (req_we[idx] || req_we[idA])) begin
`ifdef ARB_STATS_EN
            conflictSeen = 1'b1;
`endif
          end else begin
            grantB = 1'b1;
            idB    = idx;
          end
        end
      end
    end
  end

  // Grant decode, RAM port drive and next-state for pointer and read tags.
  always_comb begin
    req_ready   = '0;
    ram_we_a    = 1'b0;
    ram_addr_a  = '0;
    ram_din_a   = '0;
    ram_we_b    = 1'b0;
    ram_addr_b  = '0;
    ram_din_b   = '0;
    lastId      = grantB ? idB : idA;
    rrPtr_d     = rrPtr_q;
    tagValidA_d = grantA && !req_we[idA];
    tagValidB_d = grantB && !req_we[idB];
    if (grantA) begin
      req_ready[idA] = 1'b1;
      ram_we_a       = req_we[idA];
      ram_addr_a     = reqAddr[idA];
      ram_din_a      = reqWdata[idA];
      rrPtr_d        = (lastId == IDW'(NUM_REQ-1)) ? '0 : lastId + 1'b1;
    end
    if (grantB) begin
      req_ready[idB] = 1'b1;
      ram_we_b       = req_we[idB];
      ram_addr_b     = reqAddr[idB];
      ram_din_b      = reqWdata[idB];
    end
  end

  // Response steering: the tags captured at grant time pick which slice sees
  // this cycle's registered RAM output; other slices keep their last data.
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rspData[k] = rdataHold_q[k];
    end
    if (tagValidA_q) begin
      rsp_valid[tagIdA_q] = 1'b1;
      rspData[tagIdA_q]   = ram_dout_a;
    end
    if (tagValidB_q) begin
      rsp_valid[tagIdB_q] = 1'b1;
      rspData[tagIdB_q]   = ram_dout_b;
    end
  end

  // State registers. Clearing the tags in reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q        <= '0;
      tagValidA_q    <= 1'b0;
      tagValidB_q    <= 1'b0;
      tagIdA_q       <= '0;
      tagIdB_q       <= '0;
      errCollision_q <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        rdataHold_q[k] <= '0;
      end
    end else begin
      rrPtr_q     <= rrPtr_d;
      tagValidA_q <= tagValidA_d;
      tagValidB_q <= tagValidB_d;
      tagIdA_q    <= idA;
      tagIdB_q    <= idB;
      if (ram_collision) begin
        errCollision_q <= 1'b1;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        rdataHold_q[k] <= rspData[k];
      end
    end
  end

  assign err_collision = errCollision_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflictCnt_q <= '0;
    end else if (conflictSeen && (conflictCnt_q != 16'hFFFF)) begin
      conflictCnt_q <= conflictCnt_q + 16'd1;
    end
  end

  assign conflict_cnt = conflictCnt_q;
`endif

endmodule
